// File: rtl/operand_loader.sv
// operand_loader: debounces the load button, captures operand p then operand q from the
// switch bank on successive presses, and presents the pair downstream under valid/ready.
module operand_loader #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw,
    input  logic             load_btn,
    input  logic             out_ready,
    output logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] q,
    output logic             op_valid,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOAD_P = 2'b00,
        S_LOAD_Q = 2'b01,
        S_VALID  = 2'b10,
        S_UNUSED = 2'b11
    } state_t;

    // Debounce state: filtered level, run counter of opposite samples, press pulse
    logic             level_r;
    logic [CNT_W-1:0] cnt_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             flip_s;

    // FSM state and capture strobes
    state_t state_r;
    state_t next_state_s;
    logic   capture_p_s;
    logic   capture_q_s;

    // Count consecutive samples that disagree with the filtered level; flip on the last one
    always_comb begin
        cnt_next_s = '0;
        flip_s     = 1'b0;
        if (load_btn != level_r) begin
            if (cnt_r == CNT_LAST) begin
                flip_s     = 1'b1;
                cnt_next_s = '0;
            end else begin
                flip_s     = 1'b0;
                cnt_next_s = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_next_s = '0;
        end
    end

    // Register filtered level and emit a one-cycle press on each low-to-high flip
    always_ff @(posedge clk) begin
        if (reset) begin
            level_r <= 1'b0;
            cnt_r   <= '0;
            press_r <= 1'b0;
        end else begin
            cnt_r   <= cnt_next_s;
            level_r <= flip_s ? ~level_r : level_r;
            press_r <= flip_s & ~level_r;
        end
    end

    // Operand sequencing: p on first press, q on second, hold until downstream accepts
    always_comb begin
        next_state_s = state_r;
        capture_p_s  = 1'b0;
        capture_q_s  = 1'b0;
        case (state_r)
            S_LOAD_P: begin
                if (press_r) begin
                    capture_p_s  = 1'b1;
                    next_state_s = S_LOAD_Q;
                end else begin
                    next_state_s = S_LOAD_P;
                end
            end
            S_LOAD_Q: begin
                if (press_r) begin
                    capture_q_s  = 1'b1;
                    next_state_s = S_VALID;
                end else begin
                    next_state_s = S_LOAD_Q;
                end
            end
            S_VALID: begin
                // presses here are dropped on purpose: nothing is queued
                if (out_ready) begin
                    next_state_s = S_LOAD_P;
                end else begin
                    next_state_s = S_VALID;
                end
            end
            S_UNUSED: next_state_s = S_LOAD_P;
            default:  next_state_s = S_LOAD_P;
        endcase
    end

    // Register state, operands and the outputs decoded from the upcoming state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_LOAD_P;
            p         <= '0;
            q         <= '0;
            op_valid  <= 1'b0;
            busy      <= 1'b0;
            state_dbg <= 2'b00;
        end else begin
            state_r   <= next_state_s;
            p         <= capture_p_s ? sw : p;
            q         <= capture_q_s ? sw : q;
            op_valid  <= (next_state_s == S_VALID);
            busy      <= (next_state_s != S_LOAD_P);
            state_dbg <= next_state_s;
        end
    end

endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader: directed button/switch sequences, a behavioural model checked
// every cycle, and literal expectations at key points of each scenario.
module tb_operand_loader;

    localparam int N = 4;

    logic       clk;
    logic       reset;
    logic [1:0] sw;
    logic       load_btn;
    logic       out_ready;
    logic [1:0] p;
    logic [1:0] q;
    logic       op_valid;
    logic       busy;
    logic [1:0] state_dbg;

    int tests;
    int fails;

    operand_loader #(.WIDTH(2), .DEBOUNCE_CYCLES(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .sw        (sw),
        .load_btn  (load_btn),
        .out_ready (out_ready),
        .p         (p),
        .q         (q),
        .op_valid  (op_valid),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: run length of the current button value decides the filtered level;
    // phase counts operands held (0, 1, 2 = pair presented).
    int         m_run;
    logic       m_prev;
    logic       m_level;
    logic       m_press;
    int         m_phase;
    logic [1:0] m_p;
    logic [1:0] m_q;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Per-cycle model step on each rising edge, then compare just after the edge
    always begin
        @(posedge clk);
        if (reset) begin
            m_run = 0; m_level = 1'b0; m_press = 1'b0;
            m_phase = 0; m_p = 2'b00; m_q = 2'b00;
        end else begin
            if (m_phase == 0 && m_press) begin
                m_p = sw; m_phase = 1;
            end else if (m_phase == 1 && m_press) begin
                m_q = sw; m_phase = 2;
            end else if (m_phase == 2 && out_ready) begin
                m_phase = 0;
            end
            m_run   = (m_run > 0 && load_btn == m_prev) ? m_run + 1 : 1;
            m_press = 1'b0;
            if (load_btn != m_level && m_run >= N) begin
                m_level = load_btn;
                m_press = load_btn;
            end
        end
        m_prev = load_btn;
        #1;
        check("model_p", int'(p), int'(m_p));
        check("model_q", int'(q), int'(m_q));
        check("model_op_valid", int'(op_valid), (m_phase == 2) ? 1 : 0);
        check("model_busy", int'(busy), (m_phase != 0) ? 1 : 0);
        check("model_state", int'(state_dbg), m_phase);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic btn_for(input logic v, input int n);
        load_btn = v;
        cyc(n);
    endtask

    initial begin
        tests = 0; fails = 0;
        reset = 1'b1; sw = 2'b11; load_btn = 1'b1; out_ready = 1'b0;

        // 1. button held through reset
        cyc(3);
        check("rst_p", int'(p), 0);
        check("rst_q", int'(q), 0);
        check("rst_valid", int'(op_valid), 0);
        check("rst_state", int'(state_dbg), 0);
        reset = 1'b0;
        cyc(4);
        check("held_no_early_capture", int'(p), 0);
        cyc(1);
        check("held_capture_p", int'(p), 3);
        check("held_state_q", int'(state_dbg), 1);
        btn_for(1'b0, 5);

        // 6. reset while waiting for q, p=11
        reset = 1'b1;
        cyc(1);
        check("midrst_p", int'(p), 0);
        check("midrst_state", int'(state_dbg), 0);
        reset = 1'b0;
        cyc(2);

        // 2. normal p then q, then handshake
        sw = 2'b10;
        btn_for(1'b1, 4);
        btn_for(1'b0, 4);
        check("p_captured", int'(p), 2);
        sw = 2'b01;
        btn_for(1'b1, 4);
        load_btn = 1'b0;
        cyc(1);
        check("q_captured", int'(q), 1);
        check("valid_up", int'(op_valid), 1);
        check("state_valid", int'(state_dbg), 2);
        cyc(2);
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        check("xfer_valid_low", int'(op_valid), 0);
        check("xfer_state", int'(state_dbg), 0);
        check("xfer_p_held", int'(p), 2);
        check("xfer_q_held", int'(q), 1);

        // 3. glitchy button never settles
        sw = 2'b11;
        btn_for(1'b1, 3);
        btn_for(1'b0, 1);
        btn_for(1'b1, 3);
        btn_for(1'b0, 6);
        check("glitch_state", int'(state_dbg), 0);
        check("glitch_p", int'(p), 2);

        // 4. long hold with toggling switches: one capture only, sw seen at 5th edge
        for (int i = 0; i < 20; i++) begin
            sw = 2'(i);
            load_btn = 1'b1;
            cyc(1);
        end
        check("hold_one_capture_p", int'(p), 0);
        check("hold_state", int'(state_dbg), 1);
        btn_for(1'b0, 6);

        // 5. complete pair, then presses while stalled are discarded
        sw = 2'b11;
        btn_for(1'b1, 4);
        btn_for(1'b0, 6);
        check("pair_q", int'(q), 3);
        sw = 2'b01;
        btn_for(1'b1, 4);
        btn_for(1'b0, 4);
        btn_for(1'b1, 4);
        btn_for(1'b0, 4);
        check("stall_p", int'(p), 0);
        check("stall_q", int'(q), 3);
        check("stall_valid", int'(op_valid), 1);
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        cyc(6);
        check("no_queue_state", int'(state_dbg), 0);
        check("no_queue_p", int'(p), 0);

        // reset during a debounce count discards the partial count
        btn_for(1'b1, 2);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(4);
        check("cnt_discard_state", int'(state_dbg), 0);
        cyc(1);
        check("cnt_restart_capture", int'(state_dbg), 1);
        check("cnt_restart_p", int'(p), 1);
        btn_for(1'b0, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
